// File: rtl/pqc_pkg.sv
// Shared types and constants for the ML-KEM / ML-DSA processing-element datapath.
package pqc_pkg;

  typedef enum logic [3:0] {
    MADD   = 4'd0,
    MSUB   = 4'd1,
    MMUL   = 4'd2,
    CT_BFO = 4'd3,
    GS_BFO = 4'd4,
    P2R    = 4'd5   // handled elsewhere in the datapath; flagged as unsupported here
  } pe_instr_t;

  typedef enum logic [2:0] {
    KEM_512  = 3'd0,
    KEM_768  = 3'd1,
    KEM_1024 = 3'd2,
    DSA_44   = 3'd3,
    DSA_65   = 3'd4,
    DSA_87   = 3'd5
  } pe_alg_t;

  localparam logic [31:0] Q_KEM = 32'd3329;
  localparam logic [31:0] Q_DSA = 32'd8380417;

  // Barrett shift k is chosen so that Q*Q < 2^k; then floor(x*m/2^k) undershoots
  // floor(x/Q) by at most one and two conditional subtracts finish the job.
  localparam int BK_KEM = 24;
  localparam int BK_DSA = 46;
  localparam logic [31:0] BARRETT_KEM = 32'((64'd1 << BK_KEM) / {32'd0, Q_KEM});
  localparam logic [31:0] BARRETT_DSA = 32'((64'd1 << BK_DSA) / {32'd0, Q_DSA});

  // Control fields that travel down the pipe alongside each beat.
  typedef struct packed {
    pe_instr_t op;
    logic      err;
    logic      dsa;
  } pe_ctl_t;

  function automatic logic alg_is_kem(input pe_alg_t a);
    return a inside {KEM_512, KEM_768, KEM_1024};
  endfunction

  function automatic logic alg_is_dsa(input pe_alg_t a);
    return a inside {DSA_44, DSA_65, DSA_87};
  endfunction

  function automatic logic [31:0] q_of(input pe_alg_t a);
    return alg_is_dsa(a) ? Q_DSA : Q_KEM;
  endfunction

  function automatic logic op_legal(input pe_instr_t op);
    return op inside {MADD, MSUB, MMUL, CT_BFO, GS_BFO};
  endfunction

endpackage

// File: rtl/mod_mul_red.sv
// Per-lane modular multiplier: product registered in S2, Barrett-reduced
// combinationally in S3 ahead of the top's output register.
module mod_mul_red
  import pqc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dsa,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] red
);

  localparam int PW = 2 * WIDTH;

  logic [PW-1:0]    prod;
  logic             dsa_q;
  logic [WIDTH-1:0] q;
  logic [31:0]      m;
  logic [PW+31:0]   bp;
  logic [PW-1:0]    qhat;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] rem1;

  // S2 product register; holds with the rest of the pipe when stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod  <= '0;
      dsa_q <= 1'b0;
    end else if (en) begin
      prod  <= {{WIDTH{1'b0}}, x} * {{WIDTH{1'b0}}, y};
      dsa_q <= dsa;
    end
  end

  assign q    = dsa_q ? WIDTH'(Q_DSA) : WIDTH'(Q_KEM);
  assign m    = dsa_q ? BARRETT_DSA : BARRETT_KEM;
  assign bp   = {32'd0, prod} * {{PW{1'b0}}, m};
  assign qhat = dsa_q ? PW'(bp >> BK_DSA) : PW'(bp >> BK_KEM);
  // True remainder is below 2Q, so the low WIDTH bits carry it exactly.
  assign rem  = WIDTH'(prod - qhat * {{WIDTH{1'b0}}, q});
  assign rem1 = (rem >= q) ? rem - q : rem;
  assign red  = (rem1 >= q) ? rem1 - q : rem1;

endmodule

// File: rtl/pe_array_pipe.sv
// NUM-lane modular PE array: 3-stage pipe (operands / multiply / reduce+combine)
// with a whole-pipe stall driven by the output handshake.
module pe_array_pipe
  import pqc_pkg::*;
#(
  parameter int NUM   = 4,
  parameter int WIDTH = 32,
  parameter int TAG_W = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  pe_alg_t                         alg,
  input  pe_instr_t                       instr,
  input  logic [TAG_W-1:0]                in_tag,
  input  logic [NUM-1:0][2:0][WIDTH-1:0]  data_in,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM-1:0][1:0][WIDTH-1:0]  data_out,
  output logic [TAG_W-1:0]                out_tag,
  output logic                            out_err
);

  localparam int STAGES = 3;

  logic              advance;
  logic [STAGES:1]   vld_pipe;
  pe_ctl_t           ctl_in, ctl1, ctl2;
  logic [TAG_W-1:0]  tag1, tag2;
  logic [WIDTH-1:0]  q_in, q2;

  // in_ready is combinational from out_ready: a full pipe can accept in the
  // same cycle it retires.
  assign advance   = !vld_pipe[STAGES] || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_pipe[STAGES];
  assign q_in      = WIDTH'(q_of(alg));
  assign q2        = ctl2.dsa ? WIDTH'(Q_DSA) : WIDTH'(Q_KEM);

  function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] x, y, q);
    logic [WIDTH:0] s;
    s = {1'b0, x} + {1'b0, y};
    return (s >= {1'b0, q}) ? WIDTH'(s - {1'b0, q}) : WIDTH'(s);
  endfunction

  function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] x, y, q);
    return (x >= y) ? x - y : x - y + q;
  endfunction

  // Decode opcode/alg legality once at capture; the beat keeps flowing either way.
  always_comb begin
    ctl_in     = '0;
    ctl_in.op  = instr;
    ctl_in.dsa = alg_is_dsa(alg);
    ctl_in.err = !(op_legal(instr) && (alg_is_kem(alg) || alg_is_dsa(alg)));
  end

  // Valid shift register and control/tag pipeline; frozen as a whole on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      ctl1     <= '0;
      ctl2     <= '0;
      tag1     <= '0;
      tag2     <= '0;
      out_tag  <= '0;
      out_err  <= 1'b0;
    end else if (advance) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
      ctl1     <= ctl_in;
      ctl2     <= ctl1;
      tag1     <= in_tag;
      tag2     <= tag1;
      out_tag  <= tag2;
      out_err  <= ctl2.err;
    end
  end

  for (genvar l = 0; l < NUM; l++) begin : g_lane
    logic [WIDTH-1:0] a1, b1, w1, sum1, dif1;
    logic [WIDTH-1:0] a2, sum2, dif2;
    logic [WIDTH-1:0] mx, my, red;
    logic [WIDTH-1:0] r0_n, r1_n, r0_q, r1_q;

    // S1 operand capture with a+b / a-b prepared; S2 carries what S3 combines.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a1 <= '0; b1 <= '0; w1 <= '0; sum1 <= '0; dif1 <= '0;
        a2 <= '0; sum2 <= '0; dif2 <= '0;
        r0_q <= '0; r1_q <= '0;
      end else if (advance) begin
        a1   <= data_in[l][0];
        b1   <= data_in[l][1];
        w1   <= data_in[l][2];
        sum1 <= mod_add(data_in[l][0], data_in[l][1], q_in);
        dif1 <= mod_sub(data_in[l][0], data_in[l][1], q_in);
        a2   <= a1;
        sum2 <= sum1;
        dif2 <= dif1;
        r0_q <= r0_n;
        r1_q <= r1_n;
      end
    end

    // Multiplier operand select: a*b, b*w (CT twiddle) or (a-b)*w (GS twiddle).
    always_comb begin
      mx = '0;
      my = '0;
      case (ctl1.op)
        MMUL:    begin mx = a1;   my = b1; end
        CT_BFO:  begin mx = b1;   my = w1; end
        GS_BFO:  begin mx = dif1; my = w1; end
        default: ;
      endcase
    end

    mod_mul_red #(.WIDTH(WIDTH)) u_mmr (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (advance),
      .dsa   (ctl1.dsa),
      .x     (mx),
      .y     (my),
      .red   (red)
    );

    // S3 result combine; flagged beats are forced to zero.
    always_comb begin
      r0_n = '0;
      r1_n = '0;
      if (!ctl2.err) begin
        case (ctl2.op)
          MADD:    r0_n = sum2;
          MSUB:    r0_n = dif2;
          MMUL:    r0_n = red;
          CT_BFO:  begin r0_n = mod_add(a2, red, q2); r1_n = mod_sub(a2, red, q2); end
          GS_BFO:  begin r0_n = sum2; r1_n = red; end
          default: ;
        endcase
      end
    end

    assign data_out[l][0] = r0_q;
    assign data_out[l][1] = r1_q;
  end

endmodule

// File: tb/tb_pe_array_pipe.sv
// Self-checking bench for pe_array_pipe: directed vectors plus randomized beats
// scored against an arithmetic reference model.
module tb_pe_array_pipe;
  import pqc_pkg::*;

  typedef logic [3:0][2:0][31:0] din_t;
  typedef struct packed {
    logic [3:0][1:0][31:0] d;
    logic [7:0]            tag;
    logic                  err;
  } res_t;

  logic                  clk, rst_n, in_valid, in_ready, out_valid, out_ready, out_err;
  pe_alg_t               alg;
  pe_instr_t             instr;
  logic [7:0]            in_tag, out_tag;
  din_t                  data_in;
  logic [3:0][1:0][31:0] data_out;

  int   checks, errors, cyc;
  res_t exp_q[$];
  res_t rx_q[$];
  int   rx_cyc[$];

  pe_array_pipe #(.NUM(4), .WIDTH(32), .TAG_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alg(alg), .instr(instr), .in_tag(in_tag), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
    .out_tag(out_tag), .out_err(out_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every retired beat; handshake inputs are stable from #1 to the next edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      rx_q.push_back('{d: data_out, tag: out_tag, err: out_err});
      rx_cyc.push_back(cyc);
    end
  end

  function automatic longint tb_q(input pe_alg_t al);
    case (al)
      KEM_512, KEM_768, KEM_1024: return 3329;
      DSA_44, DSA_65, DSA_87:     return 8380417;
      default:                    return 0;
    endcase
  endfunction

  function automatic res_t model(input pe_instr_t op, input pe_alg_t al, input logic [7:0] tg, input din_t d);
    res_t r;
    longint q, a, b, w, t, r0, r1;
    r = '0;
    r.tag = tg;
    q = tb_q(al);
    if (q == 0 || !(op inside {MADD, MSUB, MMUL, CT_BFO, GS_BFO})) begin
      r.err = 1'b1;
      return r;
    end
    for (int l = 0; l < 4; l++) begin
      a = longint'(d[l][0]); b = longint'(d[l][1]); w = longint'(d[l][2]);
      r0 = 0; r1 = 0;
      case (op)
        MADD:   r0 = (a + b) % q;
        MSUB:   r0 = (a - b + q) % q;
        MMUL:   r0 = (a * b) % q;
        CT_BFO: begin t = (b * w) % q; r0 = (a + t) % q; r1 = (a - t + q) % q; end
        GS_BFO: begin r0 = (a + b) % q; r1 = (((a - b + q) % q) * w) % q; end
        default: ;
      endcase
      r.d[l][0] = 32'(r0);
      r.d[l][1] = 32'(r1);
    end
    return r;
  endfunction

  function automatic din_t vec(input logic [31:0] a, b, w);
    din_t d;
    for (int l = 0; l < 4; l++) begin d[l][0] = a; d[l][1] = b; d[l][2] = w; end
    return d;
  endfunction

  function automatic din_t rnd_din(input pe_alg_t al);
    din_t d;
    longint q;
    q = tb_q(al);
    if (q == 0) q = 3329;
    for (int l = 0; l < 4; l++)
      for (int k = 0; k < 3; k++) d[l][k] = $urandom_range(32'(q - 1));
    return d;
  endfunction

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Present a beat and hold it until accepted; expected result is queued on acceptance.
  task automatic drive(input pe_instr_t op, input pe_alg_t al, input logic [7:0] tg, input din_t d);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1; instr = op; alg = al; in_tag = tg; data_in = d;
    for (int c = 0; c < 50 && !acc; c++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
    end
    if (acc) exp_q.push_back(model(op, al, tg, d));
    else begin
      checks++; errors++;
      $display("FAIL drive_timeout tag=%h in_ready never seen within 50 cycles", tg);
    end
  endtask

  // Single beat into an idle pipe; reports the observed output and its latency.
  task automatic send1(input pe_instr_t op, input pe_alg_t al, input logic [7:0] tg, input din_t d,
                       output res_t got, output int lat);
    got = '0;
    lat = 0;
    drive(op, al, tg, d);
    in_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = c;
        got = '{d: data_out, tag: out_tag, err: out_err};
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (data_out !== '0) begin errors++; $display("FAIL reset_data_out got %h want 0", data_out); end
    checks++; if (out_tag !== 8'h00) begin errors++; $display("FAIL reset_out_tag got %h want 00", out_tag); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err got %b want 0", out_err); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_madd_msub();
    res_t got;
    int   lat;
    send1(MADD, KEM_512, 8'h01, vec(3000, 500, 0), got, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL madd_latency got %0d want 3", lat); end
    checks++; if (got.tag !== 8'h01 || got.err !== 1'b0) begin errors++; $display("FAIL madd_tag_err got %h/%b want 01/0", got.tag, got.err); end
    for (int l = 0; l < 4; l++) begin
      checks++;
      if (got.d[l][0] !== 171 || got.d[l][1] !== 0) begin errors++; $display("FAIL madd_lane%0d got %0d,%0d want 171,0", l, got.d[l][0], got.d[l][1]); end
    end
    send1(MSUB, KEM_768, 8'h02, vec(5, 10, 0), got, lat);
    checks++; if (got.d[2][0] !== 3324) begin errors++; $display("FAIL msub_wrap got %0d want 3324", got.d[2][0]); end
    send1(MADD, KEM_1024, 8'h03, vec(3000, 329, 0), got, lat);
    checks++; if (got.d[1][0] !== 0) begin errors++; $display("FAIL madd_eq_q got %0d want 0", got.d[1][0]); end
    send1(MSUB, DSA_44, 8'h04, vec(77, 77, 0), got, lat);
    checks++; if (got.d[3][0] !== 0) begin errors++; $display("FAIL msub_zero got %0d want 0", got.d[3][0]); end
  endtask

  task automatic test_mmul();
    res_t got;
    int   lat;
    send1(MMUL, KEM_512, 8'h11, vec(3328, 3328, 0), got, lat);
    checks++; if (got.d[0][0] !== 1 || got.d[0][1] !== 0) begin errors++; $display("FAIL mmul_kem_max got %0d,%0d want 1,0", got.d[0][0], got.d[0][1]); end
    send1(MMUL, DSA_65, 8'h12, vec(8380416, 2, 0), got, lat);
    checks++; if (got.d[0][0] !== 8380415) begin errors++; $display("FAIL mmul_dsa got %0d want 8380415", got.d[0][0]); end
    send1(MMUL, DSA_87, 8'h13, vec(8380416, 8380416, 0), got, lat);
    checks++; if (got.d[3][0] !== 1) begin errors++; $display("FAIL mmul_dsa_max got %0d want 1", got.d[3][0]); end
  endtask

  task automatic test_bfly();
    res_t got, want;
    int   lat;
    din_t d;
    send1(CT_BFO, KEM_512, 8'h21, vec(1, 3328, 3328), got, lat);
    checks++; if (got.d[0][0] !== 2 || got.d[0][1] !== 0) begin errors++; $display("FAIL ct_kem got %0d,%0d want 2,0", got.d[0][0], got.d[0][1]); end
    send1(GS_BFO, KEM_512, 8'h22, vec(10, 3, 2), got, lat);
    checks++; if (got.d[0][0] !== 13 || got.d[0][1] !== 14) begin errors++; $display("FAIL gs_kem got %0d,%0d want 13,14", got.d[0][0], got.d[0][1]); end
    d = rnd_din(DSA_44);
    want = model(CT_BFO, DSA_44, 8'h23, d);
    send1(CT_BFO, DSA_44, 8'h23, d, got, lat);
    checks++; if (got !== want) begin errors++; $display("FAIL ct_dsa_rand got %h want %h", got, want); end
    d = rnd_din(DSA_87);
    want = model(GS_BFO, DSA_87, 8'h24, d);
    send1(GS_BFO, DSA_87, 8'h24, d, got, lat);
    checks++; if (got !== want) begin errors++; $display("FAIL gs_dsa_rand got %h want %h", got, want); end
  endtask

  task automatic test_back_to_back();
    pe_alg_t al;
    pe_instr_t op;
    exp_q.delete(); rx_q.delete(); rx_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      al = (i % 2) ? DSA_44 : KEM_512;
      op = pe_instr_t'($urandom_range(4));
      drive(op, al, 8'(8'h30 + i), rnd_din(al));
    end
    idle(8);
    checks++; if (rx_q.size() !== exp_q.size()) begin errors++; $display("FAIL b2b_count got %0d want %0d", rx_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < rx_q.size(); k++) begin
      checks++; if (rx_q[k] !== exp_q[k]) begin errors++; $display("FAIL b2b_beat%0d got %h want %h", k, rx_q[k], exp_q[k]); end
      if (k > 0) begin
        checks++; if (rx_cyc[k] !== rx_cyc[0] + k) begin errors++; $display("FAIL b2b_rate beat%0d cycle %0d want %0d", k, rx_cyc[k], rx_cyc[0] + k); end
      end
    end
  endtask

  task automatic test_random();
    pe_alg_t al;
    pe_instr_t op;
    exp_q.delete(); rx_q.delete();
    for (int i = 0; i < 40; i++) begin
      al = pe_alg_t'($urandom_range(5));
      op = pe_instr_t'($urandom_range(4));
      drive(op, al, 8'($urandom), rnd_din(al));
      if ($urandom_range(3) == 0) begin
        out_ready = ($urandom_range(1) == 0);
        idle(1 + $urandom_range(1));
        out_ready = 1'b1;
      end
    end
    idle(8);
    checks++; if (rx_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand_count got %0d want %0d", rx_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < rx_q.size(); k++) begin
      checks++; if (rx_q[k] !== exp_q[k]) begin errors++; $display("FAIL rand_beat%0d got %h want %h", k, rx_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_illegal();
    exp_q.delete(); rx_q.delete();
    drive(MADD, KEM_512, 8'h41, rnd_din(KEM_512));
    drive(P2R, DSA_44, 8'h5A, rnd_din(DSA_44));
    drive(MMUL, DSA_44, 8'h43, rnd_din(DSA_44));
    drive(MADD, pe_alg_t'(3'd7), 8'h44, rnd_din(KEM_512));
    idle(8);
    checks++; if (rx_q.size() !== 4) begin errors++; $display("FAIL ill_count got %0d want 4", rx_q.size()); end
    if (rx_q.size() == 4) begin
      checks++; if (rx_q[1].d !== '0) begin errors++; $display("FAIL ill_data got %h want 0", rx_q[1].d); end
      checks++; if (rx_q[1].err !== 1'b1 || rx_q[1].tag !== 8'h5A) begin errors++; $display("FAIL ill_err_tag got %b/%h want 1/5a", rx_q[1].err, rx_q[1].tag); end
      checks++; if (rx_q[3].err !== 1'b1 || rx_q[3].d !== '0) begin errors++; $display("FAIL ill_alg got err %b data %h want 1/0", rx_q[3].err, rx_q[3].d); end
      for (int k = 0; k < 4; k++) begin
        checks++; if (rx_q[k] !== exp_q[k]) begin errors++; $display("FAIL ill_beat%0d got %h want %h", k, rx_q[k], exp_q[k]); end
      end
    end
  endtask

  task automatic test_backpressure();
    din_t      bd[6];
    pe_instr_t bo[6];
    pe_alg_t   ba[6];
    res_t      snap;
    bit        held;
    int        i;
    exp_q.delete(); rx_q.delete();
    for (int k = 0; k < 6; k++) begin
      ba[k] = pe_alg_t'($urandom_range(5));
      bo[k] = pe_instr_t'($urandom_range(4));
      bd[k] = rnd_din(ba[k]);
    end
    i = 0; held = 1'b0; snap = '0;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = (i < 6);
      if (i < 6) begin instr = bo[i]; alg = ba[i]; in_tag = 8'(8'h60 + i); data_in = bd[i]; end
      @(negedge clk);
      if (c == 4) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
      end
      if (out_valid) begin
        if (!held) begin snap = '{d: data_out, tag: out_tag, err: out_err}; held = 1'b1; end
        else begin
          checks++;
          if ({data_out, out_tag, out_err} !== snap) begin errors++; $display("FAIL bp_stable got %h want %h", {data_out, out_tag, out_err}, snap); end
        end
      end
      if (in_valid && in_ready) begin exp_q.push_back(model(bo[i], ba[i], 8'(8'h60 + i), bd[i])); i++; end
      @(posedge clk); #1;
    end
    checks++; if (i !== 3) begin errors++; $display("FAIL bp_held got %0d want 3", i); end
    out_ready = 1'b1;
    for (int c = 0; c < 30 && i < 6; c++) begin
      in_valid = 1'b1; instr = bo[i]; alg = ba[i]; in_tag = 8'(8'h60 + i); data_in = bd[i];
      @(negedge clk);
      if (in_ready) begin exp_q.push_back(model(bo[i], ba[i], 8'(8'h60 + i), bd[i])); i++; end
      @(posedge clk); #1;
    end
    idle(8);
    checks++; if (rx_q.size() !== 6) begin errors++; $display("FAIL bp_count got %0d want 6", rx_q.size()); end
    for (int k = 0; k < exp_q.size() && k < rx_q.size(); k++) begin
      checks++; if (rx_q[k] !== exp_q[k]) begin errors++; $display("FAIL bp_beat%0d got %h want %h", k, rx_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_reset_midstream();
    exp_q.delete(); rx_q.delete();
    out_ready = 1'b0;
    drive(MADD, KEM_512, 8'hA1, vec(1, 2, 0));
    drive(MMUL, DSA_44, 8'hA2, vec(3, 4, 0));
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid got %b want 1", out_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got %b want 1", in_ready); end
    checks++; if (data_out !== '0 || out_tag !== 8'h00) begin errors++; $display("FAIL rst_mid_data got %h/%h want 0/0", data_out, out_tag); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    out_ready = 1'b1;
    idle(10);
    checks++; if (rx_q.size() !== 0) begin errors++; $display("FAIL rst_stale got %0d beats want 0", rx_q.size()); end
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alg = KEM_512; instr = MADD; in_tag = '0; data_in = '0;
    checks = 0; errors = 0; cyc = 0;
    test_reset();
    test_madd_msub();
    test_mmul();
    test_bfly();
    test_back_to_back();
    test_random();
    test_illegal();
    test_backpressure();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
